// File: rtl/temp_conv_multi.sv
// -----------------------------------------------------------------------------
// temp_conv_multi
//
// Multi-channel temperature converter. Holds NCH Celsius sample registers
// loaded from the switch input. On a start request, converts one selected
// channel to Celsius, Fahrenheit or Kelvin:
//   C: result = sample
//   K: result = sample + 273
//   F: result = floor(9 * sample / 5) + 32, using a shift-add multiply
//      followed by a restoring divide that produces one quotient bit per cycle.
// Each conversion is framed by a start/busy/done handshake. A sticky
// per-channel alarm flags any converted sample above THRESH.
//
// Ports:
//   clk     in   system clock, all state updates on rising edge
//   clr     in   synchronous active-high reset
//   X       in   [W]      Celsius sample to load
//   ch      in   [CW]     channel index for ld and st
//   ld      in            write X into channel register ch
//   sel     in   [2]      mode: 00 C, 01 F, 10 K, 11 treated as C
//   st      in            start conversion of channel ch (accepted when idle)
//   busy    out           conversion in progress
//   done    out           one-cycle pulse, result valid
//   result  out  [W+2]    converted temperature, held until next done
//   res_ch  out  [CW]     channel that produced result
//   over    out           converted sample > THRESH, held with result
//   alarm   out  [NCH]    sticky per-channel over-temperature flags
// -----------------------------------------------------------------------------
module temp_conv_multi #(
   parameter  int unsigned W      = 8,
   parameter  int unsigned NCH    = 4,
   parameter  int unsigned THRESH = 128,
   localparam int unsigned CW     = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic           clk,
   input  logic           clr,
   input  logic [W-1:0]   X,
   input  logic [CW-1:0]  ch,
   input  logic           ld,
   input  logic [1:0]     sel,
   input  logic           st,
   output logic           busy,
   output logic           done,
   output logic [W+1:0]   result,
   output logic [CW-1:0]  res_ch,
   output logic           over,
   output logic [NCH-1:0] alarm
);

   // Result width, product width and divide step counter width.
   localparam int unsigned RW   = W + 2;
   localparam int unsigned PW   = W + 4;
   localparam int unsigned CntW = $clog2(PW);

   localparam logic [CntW-1:0] CntLast = CntW'(PW - 1);
   localparam logic [RW-1:0]   KOff    = RW'(273);
   localparam logic [RW-1:0]   FOff    = RW'(32);
   localparam logic [1:0]      SelF    = 2'b01;
   localparam logic [1:0]      SelK    = 2'b10;

   typedef enum logic [2:0] {
      StIdle,
      StCalc,
      StMul,
      StDiv,
      StAdd,
      StFin
   } state_t;

   state_t          r_state;
   logic [W-1:0]    r_chan [NCH];
   logic [W-1:0]    r_samp;
   logic [CW-1:0]   r_ch;
   logic [1:0]      r_sel;
   // During DIV, r_quo shifts dividend bits out of the top while quotient
   // bits shift in at the bottom; after PW steps it holds the full quotient.
   logic [PW-1:0]   r_quo;
   logic [2:0]      r_rem;
   logic [CntW-1:0] r_cnt;
   logic [RW-1:0]   r_acc;
   logic            r_busy;
   logic            r_done;
   logic [RW-1:0]   r_result;
   logic [CW-1:0]   r_res_ch;
   logic            r_over;
   logic [NCH-1:0]  r_alarm;

   logic [3:0]      w_trial;
   logic            w_ge;
   logic [2:0]      w_rem_nxt;
   logic [PW-1:0]   w_prod;
   logic            w_ch_ok;
   logic            w_over;

   // One restoring-divide step by 5, plus the 9*s product for the F path.
   always_comb begin
      w_trial   = {r_rem, r_quo[PW-1]};
      w_ge      = (w_trial >= 4'd5);
      w_rem_nxt = w_ge ? 3'(w_trial - 4'd5) : w_trial[2:0];
      w_prod    = (PW'(r_samp) << 3) + PW'(r_samp);
      w_ch_ok   = (32'(ch) < NCH);
      w_over    = (32'(r_samp) > THRESH);
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         r_state  <= StIdle;
         for (int i = 0; i < NCH; i++) begin
            r_chan[i] <= '0;
         end
         r_samp   <= '0;
         r_ch     <= '0;
         r_sel    <= '0;
         r_quo    <= '0;
         r_rem    <= '0;
         r_cnt    <= '0;
         r_acc    <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_result <= '0;
         r_res_ch <= '0;
         r_over   <= 1'b0;
         r_alarm  <= '0;
      end else begin
         // Loads are allowed in any state; a same-edge start still snapshots
         // the old value because both read the pre-edge register.
         if (ld && w_ch_ok) begin
            r_chan[ch] <= X;
         end

         r_done <= 1'b0;

         unique case (r_state)
            StIdle: begin
               if (st) begin
                  r_samp  <= w_ch_ok ? r_chan[ch] : '0;
                  r_ch    <= ch;
                  r_sel   <= sel;
                  r_busy  <= 1'b1;
                  r_state <= (sel == SelF) ? StMul : StCalc;
               end
            end

            StCalc: begin
               r_acc   <= (r_sel == SelK) ? (RW'(r_samp) + KOff) : RW'(r_samp);
               r_state <= StFin;
            end

            StMul: begin
               r_quo   <= w_prod;
               r_rem   <= '0;
               r_cnt   <= CntLast;
               r_state <= StDiv;
            end

            StDiv: begin
               r_quo <= {r_quo[PW-2:0], w_ge};
               r_rem <= w_rem_nxt;
               if (r_cnt == '0) begin
                  r_state <= StAdd;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end

            StAdd: begin
               // Quotient of 9*(2^W-1)/5 always fits in RW bits.
               r_acc   <= r_quo[RW-1:0] + FOff;
               r_state <= StFin;
            end

            StFin: begin
               r_result <= r_acc;
               r_res_ch <= r_ch;
               r_over   <= w_over;
               r_done   <= 1'b1;
               r_busy   <= 1'b0;
               if (w_over) begin
                  r_alarm[r_ch] <= 1'b1;
               end
               r_state <= StIdle;
            end

            default: begin
               r_state <= StIdle;
            end
         endcase
      end
   end

   assign busy   = r_busy;
   assign done   = r_done;
   assign result = r_result;
   assign res_ch = r_res_ch;
   assign over   = r_over;
   assign alarm  = r_alarm;

endmodule

// File: tb/tb_temp_conv_multi.sv
// -----------------------------------------------------------------------------
// tb_temp_conv_multi
//
// Scoreboard bench for temp_conv_multi. Each accepted start pushes the
// expected result, channel, over flag, alarm vector and latency computed from
// a bench-side model; a monitor pops and compares on every done pulse.
// -----------------------------------------------------------------------------
module tb_temp_conv_multi;

   localparam int unsigned W      = 8;
   localparam int unsigned NCH    = 4;
   localparam int unsigned THRESH = 128;
   localparam int unsigned CW     = 2;
   localparam int unsigned RW     = W + 2;

   typedef struct {
      logic [RW-1:0]  res;
      logic [CW-1:0]  ch;
      logic           over;
      logic [NCH-1:0] alarm;
      int             st_edge;
      int             lat;
   } exp_t;

   logic           clk;
   logic           clr;
   logic [W-1:0]   x;
   logic [CW-1:0]  ch;
   logic           ld;
   logic [1:0]     sel;
   logic           st;
   logic           busy;
   logic           done;
   logic [RW-1:0]  result;
   logic [CW-1:0]  res_ch;
   logic           over;
   logic [NCH-1:0] alarm;

   int             n_chk;
   int             n_pass;
   int             cyc;
   exp_t           sb [$];
   int             m_reg [NCH];
   logic [NCH-1:0] m_alarm;

   temp_conv_multi #(
      .W      (W),
      .NCH    (NCH),
      .THRESH (THRESH)
   ) u_dut (
      .clk    (clk),
      .clr    (clr),
      .X      (x),
      .ch     (ch),
      .ld     (ld),
      .sel    (sel),
      .st     (st),
      .busy   (busy),
      .done   (done),
      .result (result),
      .res_ch (res_ch),
      .over   (over),
      .alarm  (alarm)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_chk++;
      if (obs === exp_v) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp_v, $time);
      end
   endtask

   // Monitor: every done pulse must match the oldest expected conversion.
   always @(negedge clk) begin
      exp_t e;
      if (done === 1'b1) begin
         if (sb.size() == 0) begin
            check("extra_done", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            check("result", 32'(result), 32'(e.res));
            check("res_ch", 32'(res_ch), 32'(e.ch));
            check("over", 32'(over), 32'(e.over));
            check("alarm", 32'(alarm), 32'(e.alarm));
            check("busy_at_done", 32'(busy), 32'd0);
            check("latency", 32'(cyc - e.st_edge), 32'(e.lat));
         end
      end
   end

   function automatic exp_t model(input int c, input logic [1:0] s);
      exp_t e;
      int   v;
      v = m_reg[c];
      if (s == 2'b01) begin
         e.res = RW'((9 * v) / 5 + 32);
         e.lat = 15;
      end else if (s == 2'b10) begin
         e.res = RW'(v + 273);
         e.lat = 2;
      end else begin
         e.res = RW'(v);
         e.lat = 2;
      end
      e.ch   = CW'(c);
      e.over = (v > int'(THRESH));
      if (e.over) m_alarm[c] = 1'b1;
      e.alarm   = m_alarm;
      e.st_edge = cyc + 1;
      return e;
   endfunction

   task automatic do_ld(input int c, input int v);
      ld = 1'b1;
      ch = CW'(c);
      x  = W'(v);
      @(negedge clk);
      ld = 1'b0;
      m_reg[c] = v;
   endtask

   task automatic do_st(input int c, input logic [1:0] s);
      sb.push_back(model(c, s));
      st  = 1'b1;
      ch  = CW'(c);
      sel = s;
      @(negedge clk);
      st = 1'b0;
   endtask

   // Load and start on the same edge: conversion must see the old value.
   task automatic do_ld_st(input int c, input int v, input logic [1:0] s);
      sb.push_back(model(c, s));
      ld  = 1'b1;
      st  = 1'b1;
      ch  = CW'(c);
      x   = W'(v);
      sel = s;
      @(negedge clk);
      ld = 1'b0;
      st = 1'b0;
      m_reg[c] = v;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 40; i++) begin
         if (sb.size() == 0) break;
         @(negedge clk);
      end
      if (sb.size() != 0) begin
         check("done_timeout", 32'(sb.size()), 32'd0);
         sb.delete();
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      clr = 1'b1;
      repeat (2) @(negedge clk);
      clr = 1'b0;
      sb.delete();
      for (int i = 0; i < NCH; i++) m_reg[i] = 0;
      m_alarm = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_chk   = 0;
      n_pass  = 0;
      clr     = 1'b0;
      x       = '0;
      ch      = '0;
      ld      = 1'b0;
      sel     = '0;
      st      = 1'b0;
      m_alarm = '0;
      @(negedge clk);
      do_reset();

      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_result", 32'(result), 32'd0);
      check("rst_res_ch", 32'(res_ch), 32'd0);
      check("rst_over", 32'(over), 32'd0);
      check("rst_alarm", 32'(alarm), 32'd0);

      // F conversion of 100 -> 212, busy right after the start edge.
      do_ld(2, 100);
      do_st(2, 2'b01);
      check("busy_after_st", 32'(busy), 32'd1);
      wait_done();

      do_ld(0, 37);
      do_st(0, 2'b01);
      wait_done();
      do_ld(1, 255);
      do_st(1, 2'b10);
      wait_done();
      do_st(1, 2'b01);
      wait_done();

      // Alarm stickiness on ch1.
      do_ld(1, 200);
      do_st(1, 2'b00);
      wait_done();
      do_ld(1, 10);
      do_st(1, 2'b00);
      wait_done();
      check("alarm_sticky", 32'(alarm), 32'b0010);

      // Start while busy is ignored; reloads do not disturb held outputs.
      do_st(0, 2'b01);
      repeat (3) @(negedge clk);
      st  = 1'b1;
      ch  = 2'd3;
      sel = 2'b10;
      @(negedge clk);
      st = 1'b0;
      wait_done();
      do_ld(0, 250);
      repeat (20) @(negedge clk);
      check("result_held", 32'(result), 32'd98);
      check("over_held", 32'(over), 32'd0);

      // Same-edge load and start.
      do_ld(2, 50);
      do_ld_st(2, 60, 2'b00);
      wait_done();
      do_st(2, 2'b00);
      wait_done();
      do_st(2, 2'b11);
      wait_done();

      // Reset in DIV cycle 5 abandons the conversion.
      do_ld(3, 140);
      do_st(0, 2'b01);
      repeat (5) @(negedge clk);
      check("busy_mid_div", 32'(busy), 32'd1);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      sb.delete();
      for (int i = 0; i < NCH; i++) m_reg[i] = 0;
      m_alarm = '0;
      check("clr_busy", 32'(busy), 32'd0);
      check("clr_done", 32'(done), 32'd0);
      check("clr_result", 32'(result), 32'd0);
      check("clr_alarm", 32'(alarm), 32'd0);
      repeat (20) @(negedge clk);
      do_st(3, 2'b10);
      wait_done();
      do_st(1, 2'b00);
      wait_done();

      // Random conversions across channels and modes.
      for (int i = 0; i < 8; i++) begin
         int c;
         c = int'($urandom_range(NCH - 1, 0));
         do_ld(c, int'($urandom_range(255, 0)));
         do_st(c, 2'($urandom_range(3, 0)));
         wait_done();
      end

      repeat (5) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
